uart_rx_frame_ctrl: RTL and testbench
=====================================

Name: uart_rx_frame_ctrl

Overview:
- Sequences the byte stream from the UART receive block (8-bit data plus a 1-cycle valid pulse) into framed register-write packets.
- Frame format: SOF, ADDR, LEN, DATA×LEN, SUM.
- Buffers the payload and verifies the checksum. Only then does it drain the buffered payload onto a simple register-write bus, one write per cycle.
- Sits between the UART RX byte receiver and the on-chip control register file. Malformed or stalled frames produce an error pulse and never cause a write.

Parameters:
- SOF, 8'hA5, start-of-frame byte.
- MAXLEN, 16, maximum payload length in bytes. Also the payload buffer depth (1..255).
- TIMEOUT, 100000, inter-byte timeout in CLK cycles while a frame is in progress.
- AW, 8, register address width. Fixed at 8 because ADDR is one byte.

Ports:
- CLK  in  1  system clock, rising edge.
- RST_X  in  1  asynchronous active-low reset.
- rx_dot  in  8  received byte, valid only when rx_valid=1.
- rx_valid  in  1  1-cycle pulse per received byte.
- wr_en  out  1  register write strobe, 1 cycle per byte.
- wr_addr  out  8  register write address.
- wr_data  out  8  register write data.
- pkt_ok  out  1  1-cycle pulse; the frame was accepted and all its writes are issued.
- pkt_err  out  1  1-cycle pulse; the frame was discarded.
- err_code  out  2  cause of the last error: 1 = bad LEN, 2 = checksum, 3 = timeout, 0 = none since reset. Holds until the next pkt_err.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RST_X=0):
  - State goes to IDLE.
  - wr_en, pkt_ok, pkt_err, busy all go to 0.
  - wr_addr, wr_data, err_code go to 0.
  - Timeout counter, byte index and checksum accumulator go to 0.
  - Reset mid-frame discards the frame. No write and no pulse is produced for it.
- FSM states: IDLE, ADDR, LEN, DATA, SUM, DRAIN. All transitions happen on the rx_valid cycle and take effect the next edge.
- IDLE:
  - rx_valid with rx_dot==SOF → ADDR.
  - Any other byte is ignored silently (no error).
- ADDR: on rx_valid, latch ADDR, set acc=ADDR → LEN.
- LEN:
  - On rx_valid, if 1 ≤ rx_dot ≤ MAXLEN: latch LEN, acc+=LEN, idx=0 → DATA.
  - Otherwise: pkt_err=1 and err_code=1 on the next cycle → IDLE.
- DATA:
  - On rx_valid, write rx_dot to buf[idx] and do acc+=rx_dot.
  - If idx==LEN-1 → SUM; otherwise idx+=1.
- SUM:
  - On rx_valid, if (acc+rx_dot) mod 256 == 0 → DRAIN with idx=0.
  - Otherwise: pkt_err=1, err_code=2 → IDLE.
- DRAIN:
  - Each cycle: wr_en=1, wr_addr=(ADDR+idx) mod 256 (wraps FF→00), wr_data=buf[idx].
  - Outputs are registered. The first write is asserted the cycle after the accepted SUM byte.
  - After the write with idx==LEN-1, pkt_ok=1 in the following cycle → IDLE.
  - DRAIN lasts exactly LEN cycles.
  - rx_valid during DRAIN is ignored (dropped, no error). A 1-byte UART time ≫ MAXLEN cycles, so this does not happen in legal operation.
- Checksum arithmetic: acc is 8 bits, wraps mod 256, and covers ADDR, LEN, all DATA bytes and SUM. SOF is excluded.
- Timeout:
  - In ADDR, LEN, DATA and SUM, the counter reloads to 0 on each rx_valid and otherwise increments.
  - When it reaches TIMEOUT-1 with no rx_valid: pkt_err=1, err_code=3 → IDLE.
  - If rx_valid arrives in the same cycle the count hits the limit, the byte wins and the counter reloads.
  - The counter is idle in IDLE and DRAIN.
- Simultaneous events: pkt_ok and pkt_err are never both high.
- Back-to-back frames:
  - A frame may start on the first rx_valid after returning to IDLE.
  - An SOF byte received while in DATA is treated as data, not as resync.
- Payload buffer: MAXLEN×8 registers or inferred RAM, written only in DATA. Stale contents are never emitted because DRAIN reads only idx < LEN.

Test Plan:
- Good frame: A5 10 02 11 22 BB → writes (10,11) then (11,22) on 2 consecutive cycles, then pkt_ok; err_code stays 0.
- Address wrap: A5 FF 02 01 02 FC → writes (FF,01) then (00,02), then pkt_ok.
- Bad checksum: A5 10 02 11 22 BC → no wr_en, pkt_err with err_code=2. A following good frame is then accepted.
- Bad length, two cases, each giving pkt_err with err_code=1 right after the LEN byte and no writes:
  - A5 10 00.
  - A5 10 11 (LEN=17 > MAXLEN).
- Timeout: send A5 10, then silence → pkt_err with err_code=3 exactly TIMEOUT cycles after the ADDR byte. Then send A5 10 01 55 9A → write (10,55) and pkt_ok.
- Noise and reset:
  - Bytes 00 FF 5A while in IDLE → no response.
  - Assert RST_X=0 during DATA of a valid frame → no writes or pulses. After release, a full good frame completes normally.

Source files
------------

// File: rtl/uart_rx_frame_ctrl.sv
// UART byte-stream framer: SOF/ADDR/LEN/DATA/SUM frames become register writes.
// Payload is buffered and only drained to the write bus after the checksum passes.
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF     = 8'hA5,
    parameter int         MAXLEN  = 16,
    parameter int         TIMEOUT = 100000,
    parameter int         AW      = 8
) (
    input  logic          CLK,
    input  logic          RST_X,
    input  logic [7:0]    rx_dot,
    input  logic          rx_valid,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          pkt_ok,
    output logic          pkt_err,
    output logic [1:0]    err_code,
    output logic          busy
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int IW = (MAXLEN > 1) ? $clog2(MAXLEN) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [7:0]    MAXLEN8 = 8'(MAXLEN);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ADDR  = 3'd1;
    localparam logic [2:0] ST_LEN   = 3'd2;
    localparam logic [2:0] ST_DATA  = 3'd3;
    localparam logic [2:0] ST_SUM   = 3'd4;
    localparam logic [2:0] ST_DRAIN = 3'd5;

    logic [2:0]    state;
    logic [7:0]    addr_q;
    logic [7:0]    len_q;
    logic [7:0]    acc;
    logic [7:0]    idx;
    logic [TW-1:0] cnt;
    logic [7:0]    pay_mem [0:(1<<IW)-1];

    logic          in_frame;
    logic          tmo;
    logic [7:0]    nidx;
    logic [7:0]    sum_chk;

    always_comb begin
        in_frame = (state == ST_ADDR) || (state == ST_LEN) ||
                   (state == ST_DATA) || (state == ST_SUM);
        tmo      = in_frame && !rx_valid && (cnt == TO_LAST);
        nidx     = idx + 8'd1;
        sum_chk  = acc + rx_dot;
    end

    assign busy = (state != ST_IDLE);

    always_ff @(posedge CLK) begin
        if (state == ST_DATA && rx_valid)
            pay_mem[idx[IW-1:0]] <= rx_dot;
    end

    always_ff @(posedge CLK or negedge RST_X) begin
        if (!RST_X) begin
            state    <= ST_IDLE;
            addr_q   <= 8'd0;
            len_q    <= 8'd0;
            acc      <= 8'd0;
            idx      <= 8'd0;
            cnt      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= 8'd0;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            err_code <= 2'd0;
        end else begin
            wr_en   <= 1'b0;
            pkt_ok  <= 1'b0;
            pkt_err <= 1'b0;

            // Inter-byte watchdog runs only while a frame is being received
            if (!in_frame || rx_valid || tmo)
                cnt <= '0;
            else
                cnt <= cnt + 1'b1;

            case (state)
                ST_IDLE: begin
                    if (rx_valid && rx_dot == SOF)
                        state <= ST_ADDR;
                end
                ST_ADDR: begin
                    if (rx_valid) begin
                        addr_q <= rx_dot;
                        acc    <= rx_dot;
                        state  <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (rx_valid) begin
                        if (rx_dot != 8'd0 && rx_dot <= MAXLEN8) begin
                            len_q <= rx_dot;
                            acc   <= sum_chk;
                            idx   <= 8'd0;
                            state <= ST_DATA;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd1;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (rx_valid) begin
                        acc <= sum_chk;
                        if (idx == len_q - 8'd1)
                            state <= ST_SUM;
                        else
                            idx <= nidx;
                    end
                end
                ST_SUM: begin
                    if (rx_valid) begin
                        if (sum_chk == 8'd0) begin
                            wr_en   <= 1'b1;
                            wr_addr <= addr_q;
                            wr_data <= pay_mem[0];
                            idx     <= 8'd0;
                            state   <= ST_DRAIN;
                        end else begin
                            pkt_err  <= 1'b1;
                            err_code <= 2'd2;
                            state    <= ST_IDLE;
                        end
                    end
                end
                ST_DRAIN: begin
                    // The write for idx is on the bus this cycle; queue the next
                    if (idx == len_q - 8'd1) begin
                        pkt_ok <= 1'b1;
                        idx    <= 8'd0;
                        state  <= ST_IDLE;
                    end else begin
                        idx     <= nidx;
                        wr_en   <= 1'b1;
                        wr_addr <= addr_q + nidx;
                        wr_data <= pay_mem[nidx[IW-1:0]];
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (tmo) begin
                pkt_err  <= 1'b1;
                err_code <= 2'd3;
                state    <= ST_IDLE;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Directed bench for uart_rx_frame_ctrl: good, wrapped, bad, timed-out,
// noisy and reset-interrupted frames with hand-computed writes and pulse timing.
module tb_uart_rx_frame_ctrl;

    localparam int TO = 40;

    logic       CLK = 1'b0;
    logic       RST_X;
    logic [7:0] rx_dot;
    logic       rx_valid;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       pkt_ok;
    logic       pkt_err;
    logic [1:0] err_code;
    logic       busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic [7:0] wa[$];
    logic [7:0] wd[$];
    int         wc[$];
    int         nok = 0;
    int         ok_cyc = -1;
    int         nerr = 0;
    int         err_cyc = -1;
    int         both = 0;

    uart_rx_frame_ctrl #(
        .SOF(8'hA5),
        .MAXLEN(16),
        .TIMEOUT(TO),
        .AW(8)
    ) dut (
        .CLK(CLK),
        .RST_X(RST_X),
        .rx_dot(rx_dot),
        .rx_valid(rx_valid),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .pkt_ok(pkt_ok),
        .pkt_err(pkt_err),
        .err_code(err_code),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (wr_en) begin
            wa.push_back(wr_addr);
            wd.push_back(wr_data);
            wc.push_back(cyc);
        end
        if (pkt_ok) begin
            nok++;
            ok_cyc = cyc;
        end
        if (pkt_err) begin
            nerr++;
            err_cyc = cyc;
        end
        if (pkt_ok && pkt_err) both++;
    end

    task automatic clear_mon();
        wa.delete();
        wd.delete();
        wc.delete();
        nok = 0;
        ok_cyc = -1;
        nerr = 0;
        err_cyc = -1;
    endtask

    // e = cycle stamp at which the outputs of the accepting edge are sampled
    task automatic send_byte(input logic [7:0] b, output int e);
        @(negedge CLK);
        rx_dot = b;
        rx_valid = 1'b1;
        e = cyc + 1;
        @(negedge CLK);
        rx_valid = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_reset();
        RST_X = 1'b0;
        rx_valid = 1'b0;
        rx_dot = 8'h00;
        repeat (3) @(negedge CLK);
        checks++;
        if ({busy, wr_en, pkt_ok, pkt_err} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags got %b want 0000",
                     {busy, wr_en, pkt_ok, pkt_err});
        end
        checks++;
        if ({wr_addr, wr_data, err_code} !== 18'd0) begin
            failures++;
            $display("FAIL reset_values got %h/%h/%0d want 0/0/0",
                     wr_addr, wr_data, err_code);
        end
        RST_X = 1'b1;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_good(input string nm, input logic [7:0] a,
                             input int n, input logic [7:0] d0,
                             input logic [7:0] d1, input logic [7:0] s,
                             input logic [7:0] ea0, input logic [7:0] ea1,
                             input logic [1:0] ec);
        int e;
        clear_mon();
        send_byte(8'hA5, e);
        send_byte(a, e);
        send_byte(8'(n), e);
        send_byte(d0, e);
        if (n == 2) send_byte(d1, e);
        send_byte(s, e);
        repeat (n + 4) @(negedge CLK);
        checks++;
        if (wa.size() != n) begin
            failures++;
            $display("FAIL %s write_count got %0d want %0d", nm, wa.size(), n);
        end else begin
            checks++;
            if (wa[0] !== ea0 || wd[0] !== d0 || wc[0] != e) begin
                failures++;
                $display("FAIL %s write0 got (%h,%h)@%0d want (%h,%h)@%0d",
                         nm, wa[0], wd[0], wc[0], ea0, d0, e);
            end
            if (n == 2) begin
                checks++;
                if (wa[1] !== ea1 || wd[1] !== d1 || wc[1] != e + 1) begin
                    failures++;
                    $display("FAIL %s write1 got (%h,%h)@%0d want (%h,%h)@%0d",
                             nm, wa[1], wd[1], wc[1], ea1, d1, e + 1);
                end
            end
        end
        checks++;
        if (nok != 1 || ok_cyc != e + n || nerr != 0) begin
            failures++;
            $display("FAIL %s pkt_ok got n=%0d@%0d err=%0d want n=1@%0d err=0",
                     nm, nok, ok_cyc, nerr, e + n);
        end
        checks++;
        if (err_code !== ec || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s err_code/busy got %0d/%b want %0d/0",
                     nm, err_code, busy, ec);
        end
    endtask

    task automatic test_bad_sum();
        int e;
        clear_mon();
        send_byte(8'hA5, e);
        send_byte(8'h10, e);
        send_byte(8'h02, e);
        send_byte(8'h11, e);
        send_byte(8'h22, e);
        send_byte(8'hBC, e);
        repeat (6) @(negedge CLK);
        checks++;
        if (wa.size() != 0 || nok != 0) begin
            failures++;
            $display("FAIL bad_sum writes/ok got %0d/%0d want 0/0",
                     wa.size(), nok);
        end
        checks++;
        if (nerr != 1 || err_cyc != e || err_code !== 2'd2) begin
            failures++;
            $display("FAIL bad_sum pkt_err got n=%0d@%0d code=%0d want n=1@%0d code=2",
                     nerr, err_cyc, err_code, e);
        end
    endtask

    task automatic test_bad_len(input logic [7:0] len);
        int e;
        clear_mon();
        send_byte(8'hA5, e);
        send_byte(8'h10, e);
        send_byte(len, e);
        repeat (4) @(negedge CLK);
        checks++;
        if (nerr != 1 || err_cyc != e || err_code !== 2'd1) begin
            failures++;
            $display("FAIL bad_len_%h pkt_err got n=%0d@%0d code=%0d want n=1@%0d code=1",
                     len, nerr, err_cyc, err_code, e);
        end
        checks++;
        if (wa.size() != 0 || nok != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bad_len_%h writes/ok/busy got %0d/%0d/%b want 0/0/0",
                     len, wa.size(), nok, busy);
        end
    endtask

    task automatic test_timeout();
        int e;
        clear_mon();
        send_byte(8'hA5, e);
        send_byte(8'h10, e);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL timeout_busy got %b want 1", busy);
        end
        repeat (TO + 5) @(negedge CLK);
        checks++;
        if (nerr != 1 || err_cyc != e + TO || err_code !== 2'd3) begin
            failures++;
            $display("FAIL timeout pkt_err got n=%0d@%0d code=%0d want n=1@%0d code=3",
                     nerr, err_cyc, err_code, e + TO);
        end
        checks++;
        if (wa.size() != 0 || nok != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL timeout writes/ok/busy got %0d/%0d/%b want 0/0/0",
                     wa.size(), nok, busy);
        end
    endtask

    task automatic test_noise();
        int e;
        clear_mon();
        send_byte(8'h00, e);
        send_byte(8'hFF, e);
        send_byte(8'h5A, e);
        repeat (4) @(negedge CLK);
        checks++;
        if (wa.size() != 0 || nok != 0 || nerr != 0 || busy !== 1'b0 ||
            err_code !== 2'd3) begin
            failures++;
            $display("FAIL noise got w=%0d ok=%0d err=%0d busy=%b code=%0d want 0/0/0/0/3",
                     wa.size(), nok, nerr, busy, err_code);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        clear_mon();
        send_byte(8'hA5, e);
        send_byte(8'h10, e);
        send_byte(8'h02, e);
        send_byte(8'h11, e);
        RST_X = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || err_code !== 2'd0) begin
            failures++;
            $display("FAIL reset_mid_async busy/code got %b/%0d want 0/0",
                     busy, err_code);
        end
        repeat (2) @(negedge CLK);
        RST_X = 1'b1;
        send_byte(8'h22, e);
        send_byte(8'hBB, e);
        repeat (6) @(negedge CLK);
        checks++;
        if (wa.size() != 0 || nok != 0 || nerr != 0) begin
            failures++;
            $display("FAIL reset_mid got w=%0d ok=%0d err=%0d want 0/0/0",
                     wa.size(), nok, nerr);
        end
    endtask

    initial begin
        test_reset();
        test_good("good", 8'h10, 2, 8'h11, 8'h22, 8'hBB, 8'h10, 8'h11, 2'd0);
        test_good("wrap", 8'hFF, 2, 8'h01, 8'h02, 8'hFC, 8'hFF, 8'h00, 2'd0);
        test_bad_sum();
        test_good("after_bad_sum", 8'h10, 2, 8'h11, 8'h22, 8'hBB,
                  8'h10, 8'h11, 2'd2);
        test_bad_len(8'h00);
        test_bad_len(8'h11);
        test_timeout();
        test_good("after_timeout", 8'h10, 1, 8'h55, 8'h00, 8'h9A,
                  8'h10, 8'h00, 2'd3);
        test_noise();
        test_reset_mid();
        test_good("after_reset", 8'h10, 2, 8'h11, 8'h22, 8'hBB,
                  8'h10, 8'h11, 2'd0);
        checks++;
        if (both != 0) begin
            failures++;
            $display("FAIL ok_err_overlap got %0d want 0", both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
